// File: rtl/fib_seq_gen.sv
// rtl/fib_seq_gen.sv - Fibonacci-style sequence generator with valid/ready term stream
module fib_seq_gen #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [IDX_W-1:0] num_terms,
  input  logic             sat_mode,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic             out_ovf,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // a is the term on display, b is the one queued behind it; each carries
  // the carry-out of the sum that produced it.
  logic [WIDTH-1:0] a, b;
  logic             a_ovf, b_ovf;
  logic [IDX_W-1:0] idx, n;
  logic             mode;

  logic             accept;
  logic             hs;
  logic             last;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] b_nx;

  assign accept = (state == S_IDLE) && start && !abort;
  assign hs     = out_valid && out_ready;
  assign last   = (idx == (n - 1'b1));
  assign sum    = {1'b0, a} + {1'b0, b};
  assign carry  = sum[WIDTH];
  assign b_nx   = (carry && mode) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

  // Next-state selection; abort in RUN beats a completing handshake.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = (num_terms != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (hs && last) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Stream outputs are gated by state so they read as zero outside RUN.
  always_comb begin
    out_valid = (state == S_RUN);
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
    out_data  = out_valid ? a     : '0;
    out_index = out_valid ? idx   : '0;
    out_ovf   = out_valid ? a_ovf : 1'b0;
  end

  // State register plus term datapath; an aborted handshake changes nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a        <= '0;
      b        <= '0;
      a_ovf    <= 1'b0;
      b_ovf    <= 1'b0;
      idx      <= '0;
      n        <= '0;
      mode     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a        <= seed_a;
        b        <= seed_b;
        a_ovf    <= 1'b0;
        b_ovf    <= 1'b0;
        idx      <= '0;
        n        <= num_terms;
        mode     <= sat_mode;
        overflow <= 1'b0;
      end else if ((state == S_RUN) && hs && !abort) begin
        a     <= b;
        a_ovf <= b_ovf;
        b     <= b_nx;
        b_ovf <= carry;
        idx   <= idx + 1'b1;
        if (a_ovf) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
